// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_rr_arbiter : round-robin arbiter, NUM_CTRL Wishbone classic      |
// | controllers onto one target, with a per-grant response timeout.     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module wb_rr_arbiter #(
   parameter int NUM_CTRL = 2,
   parameter int TIMEOUT  = 255
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [NUM_CTRL-1:0]      c_cyc,
   input  logic [NUM_CTRL-1:0]      c_stb,
   input  logic [NUM_CTRL-1:0]      c_we,
   input  logic [NUM_CTRL*32-1:0]   c_addr,
   input  logic [NUM_CTRL*4-1:0]    c_sel,
   input  logic [NUM_CTRL*32-1:0]   c_data_wr,
   output logic [31:0]              c_data_rd,
   output logic [NUM_CTRL-1:0]      c_ack,
   output logic [NUM_CTRL-1:0]      c_err,
   output logic                     t_cyc,
   output logic                     t_stb,
   output logic                     t_we,
   output logic [31:0]              t_addr,
   output logic [3:0]               t_sel,
   output logic [31:0]              t_data_wr,
   input  logic [31:0]              t_data_rd,
   input  logic                     t_ack,
   input  logic                     t_err,
   output logic [NUM_CTRL-1:0]      o_grant,
   output logic                     o_timeout
);

   localparam int IW = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [NUM_CTRL-1:0] grant_q, grant_d;
   logic [IW-1:0]       last_q, last_d;
   logic [15:0]         wait_q, wait_d;

   logic                g_cyc, g_stb, g_we;
   logic [31:0]         g_addr, g_data;
   logic [3:0]          g_sel;
   logic [IW-1:0]       g_idx, win_idx;
   logic                win_found;
   logic                busy, live, resp, to_fire;

   // Select the granted controller's bus signals; grant is one-hot or zero.
   always_comb begin
      g_cyc  = 1'b0;
      g_stb  = 1'b0;
      g_we   = 1'b0;
      g_addr = '0;
      g_data = '0;
      g_sel  = '0;
      g_idx  = '0;
      for (int k = 0; k < NUM_CTRL; k++) begin
         if (grant_q[k]) begin
            g_cyc  = c_cyc[k];
            g_stb  = c_stb[k];
            g_we   = c_we[k];
            g_addr = c_addr[32*k +: 32];
            g_data = c_data_wr[32*k +: 32];
            g_sel  = c_sel[4*k +: 4];
            g_idx  = IW'(k);
         end
      end
   end

   // Round-robin search starting just after the previous owner.
   always_comb begin
      win_found = 1'b0;
      win_idx   = last_q;
      for (int i = 1; i <= NUM_CTRL; i++) begin
         int idx;
         idx = (int'(last_q) + i) % NUM_CTRL;
         if (!win_found && c_cyc[idx] && c_stb[idx]) begin
            win_found = 1'b1;
            win_idx   = IW'(idx);
         end
      end
   end

   assign busy    = (state_q == BUSY);
   assign live    = busy && g_cyc && g_stb;
   assign resp    = t_ack || t_err;
   // A target response in the last wait cycle takes precedence over the timeout.
   assign to_fire = live && !resp && (wait_q == 16'(TIMEOUT - 1));

   assign t_cyc     = busy && g_cyc && !to_fire;
   assign t_stb     = busy && g_stb && !to_fire;
   assign t_we      = busy && g_we;
   assign t_addr    = busy ? g_addr : 32'h0;
   assign t_sel     = busy ? g_sel  : 4'h0;
   assign t_data_wr = busy ? g_data : 32'h0;
   assign c_data_rd = t_data_rd;
   assign c_ack     = live ? (grant_q & {NUM_CTRL{t_ack}}) : '0;
   assign c_err     = live ? (grant_q & {NUM_CTRL{t_err || to_fire}}) : '0;
   assign o_grant   = grant_q;
   assign o_timeout = to_fire;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      wait_d  = wait_q;
      case (state_q)
         IDLE: begin
            wait_d = 16'h0;
            if (win_found) begin
               state_d = BUSY;
               grant_d = NUM_CTRL'(1) << win_idx;
            end
         end
         BUSY: begin
            // Completion, abort and timeout all end the grant the same way.
            if (!live || resp || to_fire) begin
               state_d = IDLE;
               grant_d = '0;
               last_d  = g_idx;
               wait_d  = 16'h0;
            end else begin
               wait_d = wait_q + 16'h1;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IW'(NUM_CTRL - 1);
         wait_q  <= 16'h0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         wait_q  <= wait_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_wb_rr_arbiter : vector table, corner sequences and random        |
// | traffic checked against a cycle model of the arbiter.               |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_wb_rr_arbiter;
   localparam int N  = 2;
   localparam int TO = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    c_cyc, c_stb, c_we, c_ack, c_err, o_grant;
   logic [N*32-1:0] c_addr, c_data_wr;
   logic [N*4-1:0]  c_sel;
   logic [31:0]     c_data_rd, t_addr, t_data_wr, t_data_rd;
   logic [3:0]      t_sel;
   logic            t_cyc, t_stb, t_we, t_ack, t_err, o_timeout;

   int nchk = 0;
   int nerr = 0;

   wb_rr_arbiter #(.NUM_CTRL(N), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst(rst),
      .c_cyc(c_cyc), .c_stb(c_stb), .c_we(c_we), .c_addr(c_addr),
      .c_sel(c_sel), .c_data_wr(c_data_wr), .c_data_rd(c_data_rd),
      .c_ack(c_ack), .c_err(c_err),
      .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we), .t_addr(t_addr),
      .t_sel(t_sel), .t_data_wr(t_data_wr), .t_data_rd(t_data_rd),
      .t_ack(t_ack), .t_err(t_err),
      .o_grant(o_grant), .o_timeout(o_timeout)
   );

   always #5 clk = ~clk;

   // Reference model: owner index (-1 when idle), previous owner, wait count.
   int m_owner, m_last, m_wait;
   logic [N-1:0] e_grant, e_ack, e_err;
   logic         e_cyc, e_stb, e_we, e_to;
   logic [31:0]  e_addr, e_data;
   logic [3:0]   e_sel;

   function automatic void model_reset();
      m_owner = -1;
      m_last  = N - 1;
      m_wait  = 0;
   endfunction

   function automatic void model_out();
      int   g;
      logic live;
      e_grant = '0; e_ack = '0; e_err = '0;
      e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_to = 1'b0;
      e_addr = '0; e_data = '0; e_sel = '0;
      if (m_owner >= 0) begin
         g = m_owner;
         e_grant[g] = 1'b1;
         e_cyc  = c_cyc[g];
         e_stb  = c_stb[g];
         e_we   = c_we[g];
         e_addr = c_addr[g*32 +: 32];
         e_data = c_data_wr[g*32 +: 32];
         e_sel  = c_sel[g*4 +: 4];
         live   = c_cyc[g] && c_stb[g];
         if (live) begin
            if (t_ack) e_ack[g] = 1'b1;
            if (t_err) e_err[g] = 1'b1;
            if (!t_ack && !t_err && m_wait == TO - 1) begin
               e_err[g] = 1'b1;
               e_to  = 1'b1;
               e_cyc = 1'b0;
               e_stb = 1'b0;
            end
         end
      end
   endfunction

   function automatic void model_next();
      int   c;
      logic live;
      if (m_owner < 0) begin
         for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (c_cyc[c] && c_stb[c]) begin
               m_owner = c;
               m_wait  = 0;
               break;
            end
         end
      end else begin
         live = c_cyc[m_owner] && c_stb[m_owner];
         if (!live || t_ack || t_err || m_wait == TO - 1) begin
            m_last  = m_owner;
            m_owner = -1;
         end else begin
            m_wait++;
         end
      end
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_all(input string tag);
      model_out();
      chk({tag, " grant"},  64'(o_grant),   64'(e_grant));
      chk({tag, " c_ack"},  64'(c_ack),     64'(e_ack));
      chk({tag, " c_err"},  64'(c_err),     64'(e_err));
      chk({tag, " t_cyc"},  64'(t_cyc),     64'(e_cyc));
      chk({tag, " t_stb"},  64'(t_stb),     64'(e_stb));
      chk({tag, " t_we"},   64'(t_we),      64'(e_we));
      chk({tag, " t_addr"}, 64'(t_addr),    64'(e_addr));
      chk({tag, " t_sel"},  64'(t_sel),     64'(e_sel));
      chk({tag, " t_wdat"}, 64'(t_data_wr), 64'(e_data));
      chk({tag, " tmo"},    64'(o_timeout), 64'(e_to));
      chk({tag, " rdat"},   64'(c_data_rd), 64'(t_data_rd));
      chk({tag, " onehot"}, 64'($countones(o_grant) <= 1), 64'(1));
   endtask

   // Inputs are already set; compare mid-cycle, then advance one edge.
   task automatic cycle(input string tag);
      #1;
      check_all(tag);
      model_next();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [N-1:0] cyc, input logic [N-1:0] stb,
                          input logic ack, input logic err);
      c_cyc = cyc; c_stb = stb; t_ack = ack; t_err = err;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      chk({tag, " rst t_stb"}, 64'(t_stb),   64'(0));
      chk({tag, " rst t_cyc"}, 64'(t_cyc),   64'(0));
      chk({tag, " rst grant"}, 64'(o_grant), 64'(0));
      chk({tag, " rst ack"},   64'(c_ack),   64'(0));
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   typedef struct {
      logic [N-1:0] cyc;
      logic [N-1:0] stb;
      logic         ack;
      logic [N-1:0] grant;
      logic         tstb;
      logic [N-1:0] cack;
   } vec_t;

   vec_t tbl[14];

   initial begin
      tbl[0]  = '{2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00};
      tbl[1]  = '{2'b11, 2'b11, 1'b0, 2'b01, 1'b1, 2'b00};
      tbl[2]  = '{2'b11, 2'b11, 1'b1, 2'b01, 1'b1, 2'b01};
      tbl[3]  = '{2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 2'b00};
      tbl[4]  = '{2'b10, 2'b10, 1'b0, 2'b10, 1'b1, 2'b00};
      tbl[5]  = '{2'b10, 2'b10, 1'b1, 2'b10, 1'b1, 2'b10};
      tbl[6]  = '{2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00};
      tbl[7]  = '{2'b11, 2'b11, 1'b1, 2'b01, 1'b1, 2'b01};
      tbl[8]  = '{2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00};
      tbl[9]  = '{2'b11, 2'b11, 1'b1, 2'b10, 1'b1, 2'b10};
      tbl[10] = '{2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00};
      tbl[11] = '{2'b11, 2'b11, 1'b0, 2'b01, 1'b1, 2'b00};
      tbl[12] = '{2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 2'b00};
      tbl[13] = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00};

      rst = 1'b1;
      c_cyc = '0; c_stb = '0; c_we = '0;
      c_addr = {32'h2000_0000, 32'h1000_0000};
      c_sel = 8'hFF;
      c_data_wr = {32'h1111_1111, 32'h0000_0000};
      t_data_rd = 32'h5A5A_0001; t_ack = 1'b0; t_err = 1'b0;
      model_reset();
      do_reset("init");

      // Arbitration order, alternation, abort and stray response in IDLE.
      for (int i = 0; i < 14; i++) begin
         set_req(tbl[i].cyc, tbl[i].stb, tbl[i].ack, 1'b0);
         #1;
         chk($sformatf("vec%0d grant", i), 64'(o_grant), 64'(tbl[i].grant));
         chk($sformatf("vec%0d t_stb", i), 64'(t_stb),   64'(tbl[i].tstb));
         chk($sformatf("vec%0d c_ack", i), 64'(c_ack),   64'(tbl[i].cack));
         model_out();
         model_next();
         @(posedge clk);
         #1;
      end

      // Controller 1 write passes through unchanged.
      c_addr[63:32] = 32'h1000_0004; c_sel[7:4] = 4'b1100;
      c_data_wr[63:32] = 32'hABCD_0000; c_we = 2'b10;
      set_req(2'b10, 2'b10, 1'b0, 1'b0);
      cycle("wr_idle");
      t_ack = 1'b1;
      #1;
      chk("wr t_addr", 64'(t_addr),    64'(32'h1000_0004));
      chk("wr t_sel",  64'(t_sel),     64'(4'b1100));
      chk("wr t_wdat", 64'(t_data_wr), 64'(32'hABCD_0000));
      chk("wr t_we",   64'(t_we),      64'(1));
      chk("wr c_ack",  64'(c_ack),     64'(2'b10));
      cycle("wr_ack");
      c_we = '0;
      set_req(2'b00, 2'b00, 1'b0, 1'b0);
      cycle("wr_done");

      // Target silent: forced error on the fourth BUSY cycle.
      set_req(2'b01, 2'b01, 1'b0, 1'b0);
      cycle("to_idle");
      for (int i = 0; i < TO - 1; i++) cycle("to_wait");
      #1;
      chk("to tmo",   64'(o_timeout), 64'(1));
      chk("to c_err", 64'(c_err),     64'(2'b01));
      chk("to t_stb", 64'(t_stb),     64'(0));
      cycle("to_fire");
      set_req(2'b00, 2'b00, 1'b0, 1'b0);
      #1;
      chk("to after grant", 64'(o_grant), 64'(0));
      cycle("to_after");

      // Response in the timeout cycle wins.
      set_req(2'b01, 2'b01, 1'b0, 1'b0);
      cycle("tack_idle");
      for (int i = 0; i < TO - 1; i++) cycle("tack_wait");
      t_ack = 1'b1;
      #1;
      chk("tack c_ack", 64'(c_ack),     64'(2'b01));
      chk("tack tmo",   64'(o_timeout), 64'(0));
      chk("tack c_err", 64'(c_err),     64'(0));
      cycle("tack_hit");
      set_req(2'b00, 2'b00, 1'b0, 1'b0);
      cycle("tack_after");

      // Asynchronous reset in BUSY, then controller 0 wins the contest.
      set_req(2'b10, 2'b10, 1'b0, 1'b0);
      cycle("rb_idle");
      #1;
      chk("rb pre t_stb", 64'(t_stb), 64'(1));
      c_cyc = 2'b11; c_stb = 2'b11;
      do_reset("rb");
      cycle("rb_arb");
      #1;
      chk("rb grant", 64'(o_grant), 64'(2'b01));
      t_ack = 1'b1;
      cycle("rb_ack");
      set_req(2'b00, 2'b00, 1'b0, 1'b0);
      cycle("rb_after");

      // Randomised traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic [N-1:0] cy;
         cy = N'($urandom_range(0, 3));
         c_cyc = cy;
         c_stb = ($urandom % 5 == 0) ? (cy & N'($urandom)) : cy;
         c_we  = N'($urandom);
         c_addr = {$urandom, $urandom};
         c_data_wr = {$urandom, $urandom};
         c_sel = 8'($urandom);
         t_data_rd = $urandom;
         t_ack = ($urandom % 4 == 0);
         t_err = ($urandom % 12 == 0);
         cycle("rnd");
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
`default_nettype wire
